obi_mux: RTL and testbench
==========================

# obi_mux

Parametrised N-master to 1-slave OBI (cv32e40p-style req/gnt/rvalid) arbiter for the core-to-bus path. Merges the core's instruction and data ports, plus any extra masters (DMA, debug), onto one slave port of `bus`. It supports fixed-priority or round-robin arbitration and keeps up to DEPTH transactions outstanding. It holds the slave-side request stable while waiting for grant, and routes in-order responses back to the issuing master.

## Interface
- `N_MASTERS`, 2: number of master ports, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, multiple of 8; byte-enable width BE_W = DATA_W/8.
- `DEPTH`, 2: maximum outstanding (granted, not yet rvalid) transactions, ≥1.
- `ARB_MODE`, 1: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `m_req`  in  N_MASTERS  per-master request.
- `m_we`  in  N_MASTERS  per-master write enable.
- `m_be`  in  N_MASTERS*BE_W  packed byte enables; master k at [k*BE_W +: BE_W].
- `m_addr`  in  N_MASTERS*ADDR_W  packed addresses.
- `m_wdata`  in  N_MASTERS*DATA_W  packed write data.
- `m_gnt`  out  N_MASTERS  per-master grant.
- `m_rvalid`  out  N_MASTERS  per-master response valid.
- `m_rdata`  out  DATA_W  read data, broadcast to all masters.
- `s_req`, `s_we`, `s_be`, `s_addr`, `s_wdata`  out  1/1/BE_W/ADDR_W/DATA_W  slave request.
- `s_gnt`, `s_rvalid`  in  1  slave grant, response valid.
- `s_rdata`  in  DATA_W  slave read data.
- `err`  out  1  sticky protocol error flag.

## Operation
- A transfer is accepted when `s_req & s_gnt` is high. `m_gnt[k] = s_gnt & s_req & (sel == k)`.
- Selection `sel` is a free choice only when state is IDLE:
  - ARB_MODE=0: lowest requesting index.
  - ARB_MODE=1: first requesting index at or after `rr_ptr`, searching upward and wrapping N_MASTERS-1 → 0.
- State machine with two states:
  - IDLE → LOCKED when `s_req` is high and `s_gnt` is low. `sel` is registered as `lock_id`.
  - LOCKED holds `sel = lock_id` and keeps `s_req` high. Other masters' requests are ignored.
  - LOCKED → IDLE on the `s_gnt` cycle.
  - This keeps address, we, be and wdata stable until grant, as OBI requires.
- `s_req = |m_req & ~full` in IDLE. `s_req = ~full | 1` in LOCKED, because a lock only forms when the FIFO was not full.
- On accept with ARB_MODE=1: `rr_ptr ← (sel+1) mod N_MASTERS`. `rr_ptr` does not move in fixed mode.
- On accept, `sel` is pushed into the ID FIFO (DEPTH entries, index width max(1,$clog2(N_MASTERS))).
- On `s_rvalid`, the head is popped and `m_rvalid[head] = 1`. All other `m_rvalid` bits are 0.
- Full FIFO blocks: `s_req` = 0 in IDLE even if a pop occurs in the same cycle. A simultaneous push and pop when not full is legal, and the count is unchanged.
- `s_rvalid` while the FIFO is empty: the response is dropped, no `m_rvalid` is asserted, and `err` is set to 1 until reset.
- Reset (mid-transaction included) behaviour:
  - FIFO is emptied and `rr_ptr` = 0.
  - State returns to IDLE and `err` = 0.
  - In-flight responses are discarded.

## Timing
- Request path is combinational, with zero added latency. `m_gnt` is asserted in the same cycle as `s_gnt`.
- Response path is combinational: `m_rvalid` is asserted in the same cycle as `s_rvalid`, and `m_rdata = s_rdata` always.
- Back-to-back accepts every cycle are supported while the FIFO is not full.
- State updates (`rr_ptr`, `lock_id`, FIFO, `err`) occur on the clock edge after the event.
- While `rst_n` is low, outputs `s_req`, `m_gnt` and `m_rvalid` are forced to 0 and `err` = 0. Data outputs are don't-care.

## Structure
- Package `obi_pkg`: constants `ARB_FIXED`=0, `ARB_RR`=1; state enum {IDLE, LOCKED}.
- Sub-module `obi_id_fifo`: synchronous FIFO of master IDs with WIDTH and DEPTH parameters. It provides push/pop/full/empty/head and is reset by `rst_n`.
- Arbiter priority search stays inline in `obi_mux`.

## Test plan
- **Round-robin:** N=2, RR mode, `s_gnt`=1 constantly, both masters requesting for 4 cycles → grants alternate 0,1,0,1. `s_rvalid` one cycle later gives `m_rvalid` 0,1,0,1.
- **Fixed priority:** N=3, fixed mode, all masters requesting, `s_gnt`=1 → master 0 is granted every cycle and masters 1 and 2 starve.
- **Lock:** master 1 requests `s_addr`=0x2000 with `s_gnt` low for 3 cycles while master 0 asserts its request in cycle 2 → `s_addr` stays 0x2000 and master 1 receives the grant.
- **Full FIFO:** DEPTH=2, two accepts with no rvalid → `s_req`=0 despite pending requests. One `s_rvalid` → `s_req` is reasserted the next cycle.
- **Stray response:** `s_rvalid` pulse with the FIFO empty → all `m_rvalid` stay 0 and `err`=1 until `rst_n` is low for a clock.
- **Reset mid-operation:** reset asserted with 1 outstanding transaction and `rr_ptr`=1 → after reset, FIFO is empty, `rr_ptr`=0, and a later `s_rvalid` sets `err`.

Source files
------------

// File: rtl/obi_pkg.sv
// obi_pkg: shared constants and types for the OBI master mux.
//   ARB_FIXED / ARB_RR : arbitration mode selectors for obi_mux.ARB_MODE
//   obi_state_e        : request-side state (IDLE = free arbitration,
//                        LOCKED = holding a presented but ungranted request)
//   id_width()         : width of a master index, never less than 1 bit
package obi_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } obi_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: synchronous FIFO of master IDs, one entry per outstanding
// transaction, so responses can be steered back in issue order.
//   clk, rst_n       clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_din    write an ID (ignored when full)
//   i_pop            drop the head entry (ignored when empty)
//   o_full, o_empty  occupancy flags
//   o_head           ID at the head; meaningful only when !o_empty
module obi_id_fifo
    import obi_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd];

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/obi_mux.sv
// obi_mux: N-master to 1-slave OBI arbiter (req/gnt/rvalid).
//   clk, rst_n                       clock, synchronous active-low reset
//   m_req/m_we/m_be/m_addr/m_wdata   packed per-master request fields
//   m_gnt, m_rvalid                  per-master grant / response valid
//   m_rdata                          slave read data, broadcast
//   s_req/s_we/s_be/s_addr/s_wdata   slave request
//   s_gnt, s_rvalid, s_rdata         slave grant / response
//   err                              sticky: response seen with nothing outstanding
// Request and response paths are combinational; IDs of accepted transfers
// are queued so in-order responses return to the right master.
module obi_mux
    import obi_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 2,
    parameter int ARB_MODE  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_MASTERS-1:0]            m_req,
    input  logic [N_MASTERS-1:0]            m_we,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_be,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    output logic [N_MASTERS-1:0]            m_gnt,
    output logic [N_MASTERS-1:0]            m_rvalid,
    output logic [DATA_W-1:0]               m_rdata,
    output logic                            s_req,
    output logic                            s_we,
    output logic [DATA_W/8-1:0]             s_be,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    input  logic                            s_gnt,
    input  logic                            s_rvalid,
    input  logic [DATA_W-1:0]               s_rdata,
    output logic                            err
);

    localparam int BE_W = DATA_W / 8;
    localparam int IDW  = id_width(N_MASTERS);

    obi_state_e     r_state;
    logic [IDW-1:0] r_lock_id;
    logic [IDW-1:0] r_rr_ptr;
    logic           r_err;

    logic [IDW-1:0] w_arb_sel;
    logic           w_found;
    logic [IDW-1:0] w_sel;
    logic           w_sreq;
    logic           w_accept;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [IDW-1:0] w_head;

    // Priority search: from index 0 in fixed mode, from r_rr_ptr (wrapping)
    // in round-robin mode.
    always_comb begin : p_arb
        int k;
        w_arb_sel = '0;
        w_found   = 1'b0;
        k         = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            k = (ARB_MODE == ARB_FIXED) ? i : (int'(r_rr_ptr) + i) % N_MASTERS;
            if (!w_found && m_req[k]) begin
                w_found   = 1'b1;
                w_arb_sel = IDW'(k);
            end
        end
    end

    // A presented-but-ungranted request is frozen on the locked master so the
    // slave sees stable address/data until it grants.
    assign w_sel    = (r_state == LOCKED) ? r_lock_id : w_arb_sel;
    assign w_sreq   = rst_n & ((r_state == LOCKED) | ((|m_req) & ~w_full));
    assign w_accept = w_sreq & s_gnt;
    assign w_pop    = rst_n & s_rvalid & ~w_empty;

    assign s_req   = w_sreq;
    assign s_we    = m_we[w_sel];
    assign s_be    = m_be[w_sel*BE_W +: BE_W];
    assign s_addr  = m_addr[w_sel*ADDR_W +: ADDR_W];
    assign s_wdata = m_wdata[w_sel*DATA_W +: DATA_W];
    assign m_rdata = s_rdata;
    assign err     = r_err & rst_n;

    always_comb begin
        m_gnt    = '0;
        m_rvalid = '0;
        if (w_accept) m_gnt[w_sel]     = 1'b1;
        if (w_pop)    m_rvalid[w_head] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lock_id <= '0;
            r_rr_ptr  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sreq && !s_gnt) begin
                        r_state   <= LOCKED;
                        r_lock_id <= w_sel;
                    end
                end
                LOCKED: begin
                    if (s_gnt) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept && ARB_MODE == ARB_RR)
                r_rr_ptr <= (w_sel == IDW'(N_MASTERS - 1)) ? '0 : w_sel + 1'b1;
            if (s_rvalid && w_empty) r_err <= 1'b1;
        end
    end

    obi_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_din   (w_sel),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_obi_mux.sv
// Bench for obi_mux: two instances share master-side stimulus.
//   A: 2 masters, round-robin, DEPTH 2    B: 3 masters, fixed priority, DEPTH 2
// A queue-based model predicts every output each cycle; directed phases add
// hand-computed expectations, then a long randomized run follows.
module tb_obi_mux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    m_req = '0;
    logic [2:0]    m_we  = '0;
    logic [3*BW-1:0] m_be = '0;
    logic [3*AW-1:0] m_addr = '0;
    logic [3*DW-1:0] m_wdata = '0;
    logic [1:0]    sgnt = '0;
    logic [1:0]    srv  = '0;
    logic [DW-1:0] s_rdata = '0;
    bit            fix_addr = 1'b0;

    logic [1:0] a_mgnt, a_mrv;
    logic [DW-1:0] a_rdata, a_swdata;
    logic [AW-1:0] a_saddr;
    logic [BW-1:0] a_sbe;
    logic a_sreq, a_swe, a_err;
    logic [2:0] b_mgnt, b_mrv;
    logic [DW-1:0] b_rdata, b_swdata;
    logic [AW-1:0] b_saddr;
    logic [BW-1:0] b_sbe;
    logic b_sreq, b_swe, b_err;

    int n_err = 0;
    int n_chk = 0;

    obi_mux #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .ARB_MODE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .m_req(m_req[1:0]), .m_we(m_we[1:0]),
        .m_be(m_be[2*BW-1:0]), .m_addr(m_addr[2*AW-1:0]), .m_wdata(m_wdata[2*DW-1:0]),
        .m_gnt(a_mgnt), .m_rvalid(a_mrv), .m_rdata(a_rdata),
        .s_req(a_sreq), .s_we(a_swe), .s_be(a_sbe), .s_addr(a_saddr), .s_wdata(a_swdata),
        .s_gnt(sgnt[0]), .s_rvalid(srv[0]), .s_rdata(s_rdata), .err(a_err));

    obi_mux #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .ARB_MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we),
        .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(b_mgnt), .m_rvalid(b_mrv), .m_rdata(b_rdata),
        .s_req(b_sreq), .s_we(b_swe), .s_be(b_sbe), .s_addr(b_saddr), .s_wdata(b_swdata),
        .s_gnt(sgnt[1]), .s_rvalid(srv[1]), .s_rdata(s_rdata), .err(b_err));

    initial forever #5 clk = ~clk;

    // Uniform view of both instances for the checker.
    logic [2:0]    o_gnt [2];
    logic [2:0]    o_rv  [2];
    logic          o_sreq[2];
    logic          o_we  [2];
    logic          o_err [2];
    logic [BW-1:0] o_be  [2];
    logic [AW-1:0] o_addr[2];
    logic [DW-1:0] o_wd  [2];
    logic [DW-1:0] o_rd  [2];
    assign o_gnt[0] = {1'b0, a_mgnt};  assign o_gnt[1] = b_mgnt;
    assign o_rv[0]  = {1'b0, a_mrv};   assign o_rv[1]  = b_mrv;
    assign o_sreq[0] = a_sreq;  assign o_sreq[1] = b_sreq;
    assign o_we[0]   = a_swe;   assign o_we[1]   = b_swe;
    assign o_err[0]  = a_err;   assign o_err[1]  = b_err;
    assign o_be[0]   = a_sbe;   assign o_be[1]   = b_sbe;
    assign o_addr[0] = a_saddr; assign o_addr[1] = b_saddr;
    assign o_wd[0]   = a_swdata; assign o_wd[1]  = b_swdata;
    assign o_rd[0]   = a_rdata; assign o_rd[1]   = b_rdata;

    // Behavioural model: outstanding IDs as a queue per instance.
    int  cfg_n   [2] = '{2, 3};
    int  cfg_mode[2] = '{1, 0};
    int  cfg_dep [2] = '{2, 2};
    bit  lk  [2];
    int  lid [2];
    int  rrp [2];
    bit  er  [2];
    int  idq [2][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int pick(input int d);
        if (lk[d]) return lid[d];
        for (int i = 0; i < cfg_n[d]; i++) begin
            int k;
            k = (cfg_mode[d] == 1) ? (rrp[d] + i) % cfg_n[d] : i;
            if (m_req[k]) return k;
        end
        return 0;
    endfunction

    function automatic bit want(input int d);
        if (lk[d]) return 1'b1;
        for (int i = 0; i < cfg_n[d]; i++)
            if (m_req[i]) return (idq[d].size() < cfg_dep[d]);
        return 1'b0;
    endfunction

    task automatic check_dut(input int d);
        string p;
        int s;
        bit sr;
        logic [2:0] eg, erv;
        p = (d == 0) ? "A" : "B";
        if (!rst_n) begin
            chk({p, ".rst_s_req"}, o_sreq[d], 0);
            chk({p, ".rst_m_gnt"}, o_gnt[d], 0);
            chk({p, ".rst_m_rvalid"}, o_rv[d], 0);
            chk({p, ".rst_err"}, o_err[d], 0);
            return;
        end
        s   = pick(d);
        sr  = want(d);
        eg  = (sr && sgnt[d]) ? 3'(1 << s) : 3'b000;
        erv = (srv[d] && idq[d].size() > 0) ? 3'(1 << idq[d][0]) : 3'b000;
        chk({p, ".s_req"}, o_sreq[d], sr);
        chk({p, ".m_gnt"}, o_gnt[d], eg);
        chk({p, ".m_rvalid"}, o_rv[d], erv);
        chk({p, ".err"}, o_err[d], er[d]);
        chk({p, ".m_rdata"}, o_rd[d], s_rdata);
        if (sr) begin
            chk({p, ".s_addr"}, o_addr[d], m_addr[s*AW +: AW]);
            chk({p, ".s_we"}, o_we[d], m_we[s]);
            chk({p, ".s_be"}, o_be[d], m_be[s*BW +: BW]);
            chk({p, ".s_wdata"}, o_wd[d], m_wdata[s*DW +: DW]);
        end
    endtask

    task automatic step(input int d);
        int s;
        bit sr, had;
        s   = pick(d);
        sr  = want(d);
        had = idq[d].size() > 0;
        if (!rst_n) begin
            lk[d] = 1'b0; rrp[d] = 0; er[d] = 1'b0; idq[d].delete();
            return;
        end
        if (srv[d]) begin
            if (had) void'(idq[d].pop_front());
            else     er[d] = 1'b1;
        end
        if (sr && sgnt[d]) begin
            idq[d].push_back(s);
            if (cfg_mode[d] == 1) rrp[d] = (s + 1) % cfg_n[d];
        end
        if (!lk[d] && sr && !sgnt[d]) begin
            lk[d] = 1'b1; lid[d] = s;
        end else if (lk[d] && sgnt[d]) begin
            lk[d] = 1'b0;
        end
    endtask

    // Compare process: inputs change at negedge, outputs sampled 3 units later.
    initial forever begin
        @(negedge clk);
        #3;
        check_dut(0);
        check_dut(1);
        step(0);
        step(1);
    end

    // One cycle of stimulus; returns at negedge+4 so literal checks follow the model check.
    task automatic cyc(input logic r, input logic [2:0] rq, input logic [1:0] g, input logic [1:0] v);
        @(negedge clk);
        rst_n   = r;
        m_req   = rq;
        sgnt    = g;
        srv     = v;
        m_we    = 3'($urandom);
        m_be    = 12'($urandom);
        m_addr  = {$urandom, $urandom, $urandom};
        m_wdata = {$urandom, $urandom, $urandom};
        s_rdata = $urandom;
        if (fix_addr) begin
            m_addr[31:0]  = 32'h1000;
            m_addr[63:32] = 32'h2000;
        end
        #4;
    endtask

    initial begin
        // reset
        cyc(0, 3'b111, 2'b11, 2'b00);
        chk("lit.rst_a_sreq", a_sreq, 0);
        chk("lit.rst_b_err", b_err, 0);
        cyc(0, 3'b111, 2'b11, 2'b11);
        chk("lit.rst_a_mrv", a_mrv, 0);

        // round-robin on A, fixed priority starvation on B
        cyc(1, 3'b111, 2'b11, 2'b00);
        chk("lit.rr1_a_gnt", a_mgnt, 2'b01); chk("lit.fx1_b_gnt", b_mgnt, 3'b001);
        cyc(1, 3'b111, 2'b11, 2'b11);
        chk("lit.rr2_a_gnt", a_mgnt, 2'b10); chk("lit.rr2_a_rv", a_mrv, 2'b01);
        chk("lit.fx2_b_gnt", b_mgnt, 3'b001); chk("lit.fx2_b_rv", b_mrv, 3'b001);
        cyc(1, 3'b111, 2'b11, 2'b11);
        chk("lit.rr3_a_gnt", a_mgnt, 2'b01); chk("lit.rr3_a_rv", a_mrv, 2'b10);
        cyc(1, 3'b111, 2'b11, 2'b11);
        chk("lit.rr4_a_gnt", a_mgnt, 2'b10); chk("lit.rr4_a_rv", a_mrv, 2'b01);
        chk("lit.fx4_b_gnt", b_mgnt, 3'b001);
        cyc(1, 3'b000, 2'b00, 2'b11);
        chk("lit.rr5_a_rv", a_mrv, 2'b10); chk("lit.fx5_b_rv", b_mrv, 3'b001);
        cyc(0, 3'b000, 2'b00, 2'b00);

        // lock: master 1 waits for grant, master 0 joins in cycle 2
        fix_addr = 1'b1;
        cyc(1, 3'b010, 2'b00, 2'b00);
        chk("lit.lk1_a_addr", a_saddr, 32'h2000); chk("lit.lk1_a_sreq", a_sreq, 1);
        cyc(1, 3'b011, 2'b00, 2'b00);
        chk("lit.lk2_a_addr", a_saddr, 32'h2000); chk("lit.lk2_b_addr", b_saddr, 32'h2000);
        cyc(1, 3'b011, 2'b00, 2'b00);
        chk("lit.lk3_a_addr", a_saddr, 32'h2000);
        cyc(1, 3'b011, 2'b11, 2'b00);
        chk("lit.lk4_a_gnt", a_mgnt, 2'b10); chk("lit.lk4_b_gnt", b_mgnt, 3'b010);
        chk("lit.lk4_a_addr", a_saddr, 32'h2000);
        cyc(1, 3'b000, 2'b00, 2'b11);
        chk("lit.lk5_a_rv", a_mrv, 2'b10); chk("lit.lk5_b_rv", b_mrv, 3'b010);
        fix_addr = 1'b0;

        // full FIFO
        cyc(1, 3'b011, 2'b11, 2'b00);
        chk("lit.full1_a_gnt", a_mgnt, 2'b01);
        cyc(1, 3'b011, 2'b11, 2'b00);
        chk("lit.full2_a_gnt", a_mgnt, 2'b10);
        cyc(1, 3'b011, 2'b11, 2'b00);
        chk("lit.full3_a_sreq", a_sreq, 0); chk("lit.full3_b_sreq", b_sreq, 0);
        cyc(1, 3'b011, 2'b11, 2'b11);
        chk("lit.full4_a_sreq", a_sreq, 0); chk("lit.full4_a_rv", a_mrv, 2'b01);
        cyc(1, 3'b011, 2'b11, 2'b00);
        chk("lit.full5_a_sreq", a_sreq, 1); chk("lit.full5_a_gnt", a_mgnt, 2'b01);
        cyc(1, 3'b000, 2'b00, 2'b11);
        cyc(1, 3'b000, 2'b00, 2'b11);

        // stray response
        cyc(1, 3'b000, 2'b00, 2'b11);
        chk("lit.stray_a_rv", a_mrv, 0); chk("lit.stray_b_rv", b_mrv, 0);
        cyc(1, 3'b000, 2'b00, 2'b00);
        chk("lit.stray_a_err", a_err, 1); chk("lit.stray_b_err", b_err, 1);
        cyc(1, 3'b000, 2'b00, 2'b00);
        chk("lit.stray_a_err2", a_err, 1);
        cyc(0, 3'b000, 2'b00, 2'b00);
        chk("lit.stray_rst_err", a_err, 0);
        cyc(1, 3'b000, 2'b00, 2'b00);
        chk("lit.stray_post_err", a_err, 0);

        // reset with one outstanding and rr_ptr = 1
        cyc(1, 3'b001, 2'b11, 2'b00);
        chk("lit.mid_a_gnt", a_mgnt, 2'b01);
        cyc(0, 3'b011, 2'b11, 2'b00);
        chk("lit.mid_rst_sreq", a_sreq, 0);
        cyc(1, 3'b000, 2'b00, 2'b11);
        chk("lit.mid_a_rv", a_mrv, 0);
        cyc(1, 3'b011, 2'b11, 2'b00);
        chk("lit.mid_a_err", a_err, 1); chk("lit.mid_a_gnt2", a_mgnt, 2'b01);
        cyc(1, 3'b000, 2'b00, 2'b11);

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [1:0] v;
            r = ($urandom_range(0, 199) != 0);
            for (int d = 0; d < 2; d++)
                v[d] = (idq[d].size() > 0) ? 1'($urandom_range(0, 1))
                                           : ($urandom_range(0, 39) == 0);
            cyc(r, 3'($urandom), 2'($urandom), v);
        end

        @(negedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
